// File: rtl/pipeline_stall_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// pipeline_stall_ctrl_pkg : FSM encodings, control bundle and MIPS branch ops
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package pipeline_stall_ctrl_pkg;

  localparam logic [1:0] ST_RUN    = 2'd0;
  localparam logic [1:0] ST_DSTALL = 2'd1;
  localparam logic [1:0] ST_CSTALL = 2'd2;

  typedef struct packed {
    logic pc_write;
    logic ifid_write;
    logic ifid_flush;
    logic idex_bubble;
    logic pc_src_branch;
  } ctrl_t;

  localparam ctrl_t CTRL_RUN   = 5'b11000;
  localparam ctrl_t CTRL_DATA  = 5'b00010;
  localparam ctrl_t CTRL_CTRL  = 5'b01100;
  localparam ctrl_t CTRL_RESET = 5'b00110;

  // Conditional-branch opcodes, shared with the hazard detection logic
  localparam logic [5:0] OP_REGIMM = 6'h01;
  localparam logic [5:0] OP_BEQ    = 6'h04;
  localparam logic [5:0] OP_BNE    = 6'h05;
  localparam logic [5:0] OP_BLEZ   = 6'h06;
  localparam logic [5:0] OP_BGTZ   = 6'h07;

  function automatic logic is_cond_branch(input logic [5:0] opcode);
    return (opcode == OP_REGIMM) || (opcode == OP_BEQ) || (opcode == OP_BNE) ||
           (opcode == OP_BLEZ)   || (opcode == OP_BGTZ);
  endfunction

endpackage

`default_nettype wire

// File: rtl/pipeline_stall_ctrl_if.sv
// ---------------------------------------------------------------------------
// pipeline_stall_ctrl_if : hazard inputs and pipeline control outputs
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

interface pipeline_stall_ctrl_if;

  logic        data_hazard;
  logic        control_hazard;
  logic        branch_resolve;
  logic        branch_taken;
  logic        pc_write;
  logic        ifid_write;
  logic        ifid_flush;
  logic        idex_bubble;
  logic        pc_src_branch;
  logic [1:0]  stall_state;
  logic        resolve_timeout;
  logic [31:0] data_stall_count;
  logic [31:0] ctrl_stall_count;

  modport slave (
    input  data_hazard, control_hazard, branch_resolve, branch_taken,
    output pc_write, ifid_write, ifid_flush, idex_bubble, pc_src_branch,
    output stall_state, resolve_timeout, data_stall_count, ctrl_stall_count
  );

  modport master (
    output data_hazard, control_hazard, branch_resolve, branch_taken,
    input  pc_write, ifid_write, ifid_flush, idex_bubble, pc_src_branch,
    input  stall_state, resolve_timeout, data_stall_count, ctrl_stall_count
  );

endinterface

`default_nettype wire

// File: rtl/pipeline_stall_ctrl_sat_counter32.sv
// ---------------------------------------------------------------------------
// sat_counter32 : 32-bit enable/clear counter that sticks at all-ones
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module sat_counter32 (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        clear,
  input  logic        en,
  output logic [31:0] count
);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (en && (count != 32'hFFFF_FFFF)) begin
      count <= count + 32'd1;
    end
  end

endmodule

`default_nettype wire

// File: rtl/pipeline_stall_ctrl.sv
// ---------------------------------------------------------------------------
// pipeline_stall_ctrl : data/control hazard stall and flush FSM.
// Optional perf counters under macro STALL_PERF_EN.  Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module pipeline_stall_ctrl
  import pipeline_stall_ctrl_pkg::*;
#(
  parameter int DATA_STALL_CYCLES = 2,
  parameter int RESOLVE_TIMEOUT   = 4
) (
  input  logic                  clk,
  input  logic                  reset_n,
  pipeline_stall_ctrl_if.slave  bus
);

  localparam int CNT_W  = $clog2(DATA_STALL_CYCLES) + 1;
  localparam int TCNT_W = $clog2(RESOLVE_TIMEOUT) + 1;
  localparam logic [CNT_W-1:0]  CNT_LOAD  =
      CNT_W'((DATA_STALL_CYCLES > 1) ? (DATA_STALL_CYCLES - 2) : 0);
  localparam logic [TCNT_W-1:0] TCNT_LAST = TCNT_W'(RESOLVE_TIMEOUT - 1);

  logic [1:0]        state, state_nxt;
  logic [CNT_W-1:0]  cnt, cnt_nxt;
  logic [TCNT_W-1:0] tcnt, tcnt_nxt;
  logic              timeout_set;
  logic              timeout_q;
  ctrl_t             ctrl;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= ST_RUN;
      cnt       <= '0;
      tcnt      <= '0;
      timeout_q <= 1'b0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      tcnt  <= tcnt_nxt;
      if (timeout_set) begin
        timeout_q <= 1'b1;
      end
    end
  end

  // Outputs are decoded from the current state and inputs so a stall
  // bites in the same cycle the hazard is flagged.
  always_comb begin
    state_nxt   = state;
    cnt_nxt     = cnt;
    tcnt_nxt    = tcnt;
    timeout_set = 1'b0;
    ctrl        = CTRL_RUN;
    case (state)
      ST_RUN: begin
        if (bus.data_hazard) begin
          ctrl = CTRL_DATA;
          if (DATA_STALL_CYCLES > 1) begin
            state_nxt = ST_DSTALL;
            cnt_nxt   = CNT_LOAD;
          end
        end else if (bus.control_hazard) begin
          ctrl      = CTRL_CTRL;
          state_nxt = ST_CSTALL;
          tcnt_nxt  = '0;
        end
      end
      ST_DSTALL: begin
        ctrl = CTRL_DATA;
        if (cnt == '0) begin
          state_nxt = ST_RUN;
        end else begin
          cnt_nxt = cnt - CNT_W'(1);
        end
      end
      ST_CSTALL: begin
        ctrl = CTRL_CTRL;
        if (bus.branch_resolve) begin
          ctrl.pc_write      = 1'b1;
          ctrl.pc_src_branch = bus.branch_taken;
          state_nxt          = ST_RUN;
        end else if (tcnt == TCNT_LAST) begin
          ctrl.pc_write = 1'b1;
          timeout_set   = 1'b1;
          state_nxt     = ST_RUN;
        end else begin
          tcnt_nxt = tcnt + TCNT_W'(1);
        end
      end
      default: begin
        ctrl      = CTRL_RESET;
        state_nxt = ST_RUN;
      end
    endcase
    if (!reset_n) begin
      ctrl = CTRL_RESET;
    end
  end

  assign bus.pc_write        = ctrl.pc_write;
  assign bus.ifid_write      = ctrl.ifid_write;
  assign bus.ifid_flush      = ctrl.ifid_flush;
  assign bus.idex_bubble     = ctrl.idex_bubble;
  assign bus.pc_src_branch   = ctrl.pc_src_branch;
  assign bus.stall_state     = state;
  assign bus.resolve_timeout = timeout_q;

`ifdef STALL_PERF_EN
  logic data_stall_cyc;
  logic ctrl_stall_cyc;

  assign data_stall_cyc = ((state == ST_RUN) && bus.data_hazard) || (state == ST_DSTALL);
  assign ctrl_stall_cyc = (state == ST_CSTALL);

  sat_counter32 u_data_cnt (
    .clk     (clk),
    .reset_n (reset_n),
    .clear   (1'b0),
    .en      (data_stall_cyc),
    .count   (bus.data_stall_count)
  );

  sat_counter32 u_ctrl_cnt (
    .clk     (clk),
    .reset_n (reset_n),
    .clear   (1'b0),
    .en      (ctrl_stall_cyc),
    .count   (bus.ctrl_stall_count)
  );
`else
  assign bus.data_stall_count = '0;
  assign bus.ctrl_stall_count = '0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_pipeline_stall_ctrl.sv
// ---------------------------------------------------------------------------
// tb_pipeline_stall_ctrl : directed scoreboard bench for pipeline_stall_ctrl
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_pipeline_stall_ctrl;

`ifdef STALL_PERF_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  // {pc_write, ifid_write, ifid_flush, idex_bubble, pc_src_branch}
  localparam logic [4:0] O_RUN = 5'b11000;
  localparam logic [4:0] O_RST = 5'b00110;
  localparam logic [4:0] O_DAT = 5'b00010;
  localparam logic [4:0] O_CTL = 5'b01100;
  localparam logic [4:0] O_TKN = 5'b11101;
  localparam logic [4:0] O_NTK = 5'b11100;

  typedef struct {
    logic [4:0] ctl;
    logic [1:0] st;
    logic       to;
    bit         ck;
    int         dc;
    int         cc;
  } exp_t;

  logic clk;
  logic reset_n;
  int   vectors;
  int   errors;
  exp_t exp_q[$];
  exp_t e;
  logic [4:0]  got_ctl;
  logic [31:0] want_dc, want_cc;

  pipeline_stall_ctrl_if bus ();

  pipeline_stall_ctrl #(
    .DATA_STALL_CYCLES (2),
    .RESOLVE_TIMEOUT   (4)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic cyc(input logic rn, input logic dh, input logic ch, input logic br,
                     input logic bt, input logic [4:0] ctl, input logic [1:0] st,
                     input logic to, input bit ck, input int dc, input int cc);
    exp_t x;
    @(posedge clk);
    #1;
    reset_n            = rn;
    bus.data_hazard    = dh;
    bus.control_hazard = ch;
    bus.branch_resolve = br;
    bus.branch_taken   = bt;
    x.ctl = ctl; x.st = st; x.to = to; x.ck = ck; x.dc = dc; x.cc = cc;
    exp_q.push_back(x);
  endtask

  // Monitor: outputs are valid every cycle, checked mid-cycle
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      vectors++;
      got_ctl = {bus.pc_write, bus.ifid_write, bus.ifid_flush, bus.idex_bubble, bus.pc_src_branch};
      if (got_ctl !== e.ctl) begin
        errors++;
        $display("FAIL ctl vec %0d: got %b want %b", vectors, got_ctl, e.ctl);
      end
      if (bus.stall_state !== e.st) begin
        errors++;
        $display("FAIL stall_state vec %0d: got %0d want %0d", vectors, bus.stall_state, e.st);
      end
      if (bus.resolve_timeout !== e.to) begin
        errors++;
        $display("FAIL resolve_timeout vec %0d: got %b want %b", vectors, bus.resolve_timeout, e.to);
      end
      if (e.ck) begin
        want_dc = PERF ? 32'(e.dc) : 32'd0;
        want_cc = PERF ? 32'(e.cc) : 32'd0;
        if (bus.data_stall_count !== want_dc) begin
          errors++;
          $display("FAIL data_stall_count vec %0d: got %0d want %0d", vectors, bus.data_stall_count, want_dc);
        end
        if (bus.ctrl_stall_count !== want_cc) begin
          errors++;
          $display("FAIL ctrl_stall_count vec %0d: got %0d want %0d", vectors, bus.ctrl_stall_count, want_cc);
        end
      end
    end
  end

  initial begin
    vectors = 0;
    errors  = 0;
    reset_n            = 1'b0;
    bus.data_hazard    = 1'b0;
    bus.control_hazard = 1'b0;
    bus.branch_resolve = 1'b0;
    bus.branch_taken   = 1'b0;

    // Reset hold with a hazard asserted
    for (int i = 0; i < 3; i++) cyc(0, 1, 0, 0, 0, O_RST, 2'd0, 0, 1, 0, 0);
    cyc(1, 0, 0, 0, 0, O_RUN, 2'd0, 0, 1, 0, 0);

    // Single data hazard: two bubble cycles
    cyc(1, 1, 0, 0, 0, O_DAT, 2'd0, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 0, O_DAT, 2'd1, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 0, O_RUN, 2'd0, 0, 1, 2, 0);

    // Taken branch resolved in the second CSTALL cycle
    cyc(1, 0, 1, 0, 0, O_CTL, 2'd0, 0, 0, 0, 0);
    cyc(1, 0, 1, 0, 0, O_CTL, 2'd2, 0, 0, 0, 0);
    cyc(1, 0, 1, 1, 1, O_TKN, 2'd2, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 0, O_RUN, 2'd0, 0, 1, 2, 2);

    // Both hazards: data first, then the branch, resolved not-taken
    cyc(1, 1, 1, 0, 0, O_DAT, 2'd0, 0, 0, 0, 0);
    cyc(1, 1, 1, 0, 0, O_DAT, 2'd1, 0, 0, 0, 0);
    cyc(1, 0, 1, 0, 0, O_CTL, 2'd0, 0, 0, 0, 0);
    cyc(1, 0, 1, 0, 0, O_CTL, 2'd2, 0, 0, 0, 0);
    cyc(1, 0, 1, 1, 0, O_NTK, 2'd2, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 0, O_RUN, 2'd0, 0, 1, 4, 4);

    // Back-to-back data stalls; resolve pulses in DSTALL/RUN ignored
    cyc(1, 1, 0, 0, 0, O_DAT, 2'd0, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 0, O_DAT, 2'd1, 0, 0, 0, 0);
    cyc(1, 1, 0, 0, 0, O_DAT, 2'd0, 0, 0, 0, 0);
    cyc(1, 0, 0, 1, 1, O_DAT, 2'd1, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 0, O_RUN, 2'd0, 0, 1, 8, 4);
    cyc(1, 0, 0, 1, 1, O_RUN, 2'd0, 0, 1, 8, 4);

    // Timeout after four unresolved CSTALL cycles, then sticky flag
    cyc(1, 0, 1, 0, 0, O_CTL, 2'd0, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) cyc(1, 0, 1, 0, 0, O_CTL, 2'd2, 0, 0, 0, 0);
    cyc(1, 0, 1, 0, 0, O_NTK, 2'd2, 0, 0, 0, 0);
    for (int i = 0; i < 10; i++) cyc(1, 0, 0, 0, 0, O_RUN, 2'd0, 1, 1, 8, 8);

    // Reset mid-CSTALL at tcnt=2, then a spurious resolve
    cyc(1, 0, 1, 0, 0, O_CTL, 2'd0, 1, 0, 0, 0);
    cyc(1, 0, 1, 0, 0, O_CTL, 2'd2, 1, 0, 0, 0);
    cyc(1, 0, 1, 0, 0, O_CTL, 2'd2, 1, 1, 8, 9);
    cyc(0, 0, 1, 0, 0, O_RST, 2'd0, 0, 1, 0, 0);
    cyc(1, 0, 0, 1, 1, O_RUN, 2'd0, 0, 1, 0, 0);
    cyc(1, 0, 0, 0, 0, O_RUN, 2'd0, 0, 1, 0, 0);

    for (int i = 0; i < 4 && exp_q.size() > 0; i++) @(negedge clk);
    #1;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending want 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule

`default_nettype wire
